fft_cbfp_seq: RTL

Frame sequencer for the CBFP (convergent block floating point) normalisation stage of the 512-point FFT. It admits 16-sample beats from the upstream butterfly stage only when a downstream frame buffer slot is free, and drives the CBFP `i_valid` as one contiguous 32-beat burst per frame. It inserts the mandatory idle cycle between frames, aborts malformed frames, and tags the CBFP outputs with start-of-frame and end-of-frame markers. It also reduces the per-beat shift indices into one frame exponent for the next stage.

---
 rtl/fft_cbfp_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fft_cbfp_seq.sv
// Frame sequencer for the CBFP normalisation stage: credit-gated beat admission,
// one contiguous valid burst per frame, SOF/EOF tagging and frame exponent reduction.
module fft_cbfp_seq #(
  parameter int BEATS   = 32,
  parameter int IDX_W   = 5,
  parameter int CREDITS = 2,
  parameter int FID_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             cbfp_valid,
  input  logic [IDX_W-1:0] beat_shift_lo,
  input  logic [IDX_W-1:0] beat_shift_hi,
  input  logic             credit_return,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_exp,
  output logic [FID_W-1:0] frame_id,
  output logic             frame_err,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int BCNT_W = $clog2(BEATS);
  localparam int CRD_W  = $clog2(CREDITS + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, ABORT} state_t;

  state_t            state, state_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic [CRD_W-1:0]  credits;
  logic              ready_st;
  logic              take;
  logic              abort_st;

  logic              vld_p1, sof_p1, eof_p1;
  logic [IDX_W-1:0]  beat_min, run_min;

  function automatic logic [IDX_W-1:0] umin(input logic [IDX_W-1:0] a,
                                            input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Net of take/return events, clamped so surplus returns are dropped.
  function automatic logic [CRD_W-1:0] credit_next(input logic [CRD_W-1:0] c,
                                                   input logic t, input logic r,
                                                   input logic a);
    logic [CRD_W:0] s;
    s = {1'b0, c} + {{CRD_W{1'b0}}, r} + {{CRD_W{1'b0}}, a} - {{CRD_W{1'b0}}, t};
    if (s > (CRD_W+1)'(CREDITS)) s = (CRD_W+1)'(CREDITS);
    return s[CRD_W-1:0];
  endfunction

  // Stage p0: admission; ready is forced low while reset is asserted.
  assign s_ready    = ready_st & rst_n;
  assign cbfp_valid = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcnt    <= '0;
      credits <= CRD_W'(CREDITS);
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      credits <= credit_next(credits, take, credit_return, abort_st);
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (cbfp_valid) begin
          bcnt_nxt  = BCNT_W'(1);
          state_nxt = s_last ? ABORT : RUN;
        end
      end
      RUN: begin
        if (!s_valid) begin
          state_nxt = ABORT;
        end else if (bcnt == LAST_BEAT) begin
          state_nxt = TAIL;
          bcnt_nxt  = '0;
        end else if (s_last) begin
          state_nxt = ABORT;
        end else begin
          bcnt_nxt = bcnt + BCNT_W'(1);
        end
      end
      TAIL:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_st = 1'b0;
    take     = 1'b0;
    abort_st = 1'b0;
    case (state)
      IDLE: begin
        ready_st = (credits != '0);
        take     = cbfp_valid;
      end
      RUN:     ready_st = 1'b1;
      ABORT:   abort_st = 1'b1;
      default: ready_st = 1'b0;
    endcase
  end

  assign frame_err = abort_st;
  assign busy      = (state != IDLE);

  // Stage p1: tags aligned with the CBFP registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= cbfp_valid;
      sof_p1 <= cbfp_valid && (state == IDLE);
      eof_p1 <= cbfp_valid && (state == RUN) && (bcnt == LAST_BEAT);
    end
  end

  assign m_valid  = vld_p1;
  assign m_sof    = sof_p1;
  assign m_eof    = eof_p1;
  assign beat_min = umin(beat_shift_lo, beat_shift_hi);

  always_ff @(posedge clk) begin
    if (vld_p1) run_min <= sof_p1 ? beat_min : umin(run_min, beat_min);
  end

  // Stage p2: frame completion, exponent and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_exp  <= '0;
      frame_id   <= '0;
      err_count  <= '0;
    end else begin
      frame_done <= vld_p1 & eof_p1;
      if (vld_p1 && eof_p1) begin
        frame_exp <= umin(run_min, beat_min);
        frame_id  <= frame_id + FID_W'(1);
      end
      if (abort_st) err_count <= sat_inc8(err_count);
    end
  end

endmodule
